regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter data_width, default 32, giving the write-data width.
REQ-002 The block SHALL have parameter select_width, default 5, giving the register-address width; the register count is 2**select_width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, 3, one write-request valid per requester (bit i = requester i).
REQ-006 The block SHALL have port req_ready, output, 3, combinational grant per requester; a transfer occurs when req_valid[i] & req_ready[i].
REQ-007 The block SHALL have ports req_addr_0/1/2, input, select_width each, giving the target register per requester.
REQ-008 The block SHALL have ports req_data_0/1/2, input, data_width each, giving the write data per requester.
REQ-009 The block SHALL have port clear_start, input, 1, a request to zero the whole register file.
REQ-010 The block SHALL have port clear_busy, output, 1, high while in state CLEAR.
REQ-011 The block SHALL have port clear_done, output, 1, a one-cycle pulse when the final clear write is presented.
REQ-012 The block SHALL have port RegWrite, output, 1, registered write enable to the register file.
REQ-013 The block SHALL have port write_address, output, select_width, registered write address.
REQ-014 The block SHALL have port write_data, output, data_width, registered write data.
REQ-015 The block SHALL have port grant_id, output, 2, registered index of the requester whose write is on the outputs (3 = clear engine).

Function
REQ-016 The FSM SHALL have two states: ARB and CLEAR.
- ARB -> CLEAR when clear_start=1.
- CLEAR -> ARB after the write to address 2**select_width-1 is loaded.
REQ-017 In ARB with clear_start=0 and any req_valid set, exactly one req_ready bit SHALL assert, selected round-robin: search order starts at last_grant+1 mod 3 and wraps.
REQ-018 last_grant SHALL update to the granted index only on a transfer; with no valid requests it SHALL hold.
REQ-019 A transfer at edge k SHALL make RegWrite=1, write_address/write_data = the granted requester's addr/data, and grant_id = its index visible from edge k until edge k+1 (latency 1 cycle).
REQ-020 In any cycle without a transfer or clear write, RegWrite SHALL be 0; write_address, write_data and grant_id SHALL hold their previous values.
REQ-021 When clear_start and req_valid are high in the same ARB cycle, clear SHALL win: req_ready=0 and no transfer that cycle.
REQ-022 In CLEAR, req_ready SHALL be 0 and clear_start SHALL be ignored.
REQ-023 In CLEAR, a select_width-bit counter starting at 0 SHALL load one write per cycle with write_address=counter, write_data=0, grant_id=3, RegWrite=1, covering all 2**select_width addresses in ascending order with no gaps.
REQ-024 The clear_done register SHALL be 1 in exactly the cycle the address 2**select_width-1 write is on the outputs; otherwise it SHALL be 0.
REQ-025 The FSM SHALL enter ARB after that final clear write is loaded; requests SHALL be grantable in the same cycle clear_done=1.
REQ-026 The counter SHALL reset to 0 on each entry to CLEAR.
REQ-027 Writes to address 0 SHALL be treated like any other address (no hard-wired zero register).
REQ-028 Arbitration SHALL not depend on address; two requesters targeting the same address SHALL be serialized in grant order.

Reset
REQ-029 While rst_n=0, the block SHALL be held in state ARB with: counter=0, last_grant=2 (requester 0 highest priority first), RegWrite=0, write_address=0, write_data=0, grant_id=0, clear_done=0, clear_busy=0.
REQ-030 Assertion of rst_n mid-CLEAR SHALL abort the clear immediately, with no further clear writes and no clear_done pulse.

Verification
REQ-031 The bench SHALL cover: after reset, req_valid=3'b111 held for 3 cycles -> grants 0,1,2 in order; RegWrite=1 each following cycle with grant_id 0,1,2.
REQ-032 The bench SHALL cover: only req_valid[1] with addr=7, data=32'hDEADBEEF -> req_ready=3'b010 same cycle; next cycle RegWrite=1, write_address=7, write_data=32'hDEADBEEF.
REQ-033 The bench SHALL cover: clear_start pulse with req_valid[0]=1 -> req_ready=0; 32 consecutive RegWrite cycles at addresses 0..31 with data 0 and grant_id=3; clear_done=1 only with address 31; requester 0 granted in that same cycle.
REQ-034 The bench SHALL cover: rst_n low after clear write to address 10 -> all outputs at reset values asynchronously; after release, no clear writes and no clear_done.
REQ-035 The bench SHALL cover: clear_start re-pulsed during CLEAR -> ignored; still exactly 32 writes and one clear_done.
REQ-036 The bench SHALL cover: idle cycle between grants (last_grant=1) followed by req_valid=3'b011 -> requester 0 granted (search from 2 wraps to 0).

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin write arbiter for three register-file writers, with a
// sequential clear engine that zeroes every register one write per cycle.
module regfile_write_arbiter #(
   parameter int data_width   = 32,
   parameter int select_width = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [2:0]              req_valid,
   output logic [2:0]              req_ready,
   input  logic [select_width-1:0] req_addr_0,
   input  logic [select_width-1:0] req_addr_1,
   input  logic [select_width-1:0] req_addr_2,
   input  logic [data_width-1:0]   req_data_0,
   input  logic [data_width-1:0]   req_data_1,
   input  logic [data_width-1:0]   req_data_2,
   input  logic                    clear_start,
   output logic                    clear_busy,
   output logic                    clear_done,
   output logic                    RegWrite,
   output logic [select_width-1:0] write_address,
   output logic [data_width-1:0]   write_data,
   output logic [1:0]              grant_id
);

   typedef enum logic {ARB, CLEAR} state_t;

   localparam logic [select_width-1:0] LAST_ADDR = '1;

   state_t                  state_q, state_d;
   logic [select_width-1:0] cnt_q, cnt_d;
   logic [1:0]              last_q, last_d;
   logic                    regwrite_q, regwrite_d;
   logic [select_width-1:0] waddr_q, waddr_d;
   logic [data_width-1:0]   wdata_q, wdata_d;
   logic [1:0]              gid_q, gid_d;
   logic                    done_q, done_d;

   logic [2:0] ready;
   logic [1:0] sel;
   logic [1:0] order [3];

   // order[0] is the highest-priority requester for this cycle
   always_comb begin
      ready = '0;
      sel   = 2'd0;
      unique case (last_q)
         2'd0:    order = '{2'd1, 2'd2, 2'd0};
         2'd1:    order = '{2'd2, 2'd0, 2'd1};
         default: order = '{2'd0, 2'd1, 2'd2};
      endcase
      if (state_q == ARB && !clear_start && |req_valid) begin
         for (int k = 2; k >= 0; k--) begin
            if (req_valid[order[k]]) sel = order[k];
         end
         ready[sel] = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      regwrite_d = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      gid_d      = gid_q;
      done_d     = 1'b0;
      unique case (state_q)
         ARB: begin
            if (clear_start) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end else if (|ready) begin
               regwrite_d = 1'b1;
               last_d     = sel;
               gid_d      = sel;
               unique case (1'b1)
                  ready[0]: begin
                     waddr_d = req_addr_0;
                     wdata_d = req_data_0;
                  end
                  ready[1]: begin
                     waddr_d = req_addr_1;
                     wdata_d = req_data_1;
                  end
                  ready[2]: begin
                     waddr_d = req_addr_2;
                     wdata_d = req_data_2;
                  end
               endcase
            end
         end
         CLEAR: begin
            regwrite_d = 1'b1;
            waddr_d    = cnt_q;
            wdata_d    = '0;
            gid_d      = 2'd3;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d = ARB;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ARB;
         cnt_q      <= '0;
         last_q     <= 2'd2;
         regwrite_q <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         gid_q      <= 2'd0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         regwrite_q <= regwrite_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         gid_q      <= gid_d;
         done_q     <= done_d;
      end
   end

   assign req_ready     = ready;
   assign clear_busy    = (state_q == CLEAR);
   assign clear_done    = done_q;
   assign RegWrite      = regwrite_q;
   assign write_address = waddr_q;
   assign write_data    = wdata_q;
   assign grant_id      = gid_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: stimulus pushes expected writes, a negedge monitor
// pops and compares every write the arbiter presents.
module tb_regfile_write_arbiter;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      logic [1:0]  gid;
      logic        done;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  req_valid = '0;
   logic [2:0]  req_ready;
   logic        clear_start = 1'b0;
   logic        clear_busy, clear_done, RegWrite;
   logic [4:0]  write_address;
   logic [31:0] write_data;
   logic [1:0]  grant_id;
   logic [4:0]  a [3];
   logic [31:0] d [3];

   exp_t sb[$];
   int   tests = 0;
   int   failed = 0;

   always #5 clk = ~clk;

   regfile_write_arbiter #(.data_width(32), .select_width(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr_0(a[0]), .req_addr_1(a[1]), .req_addr_2(a[2]),
      .req_data_0(d[0]), .req_data_1(d[1]), .req_data_2(d[2]),
      .clear_start(clear_start), .clear_busy(clear_busy),
      .clear_done(clear_done), .RegWrite(RegWrite),
      .write_address(write_address), .write_data(write_data),
      .grant_id(grant_id)
   );

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   // one arbitration cycle; inputs return to idle after the edge
   task automatic step(input logic [2:0] v, input logic c,
                       input logic [2:0] er);
      @(negedge clk);
      req_valid   = v;
      clear_start = c;
      #1;
      chk("req_ready", {29'd0, req_ready}, {29'd0, er});
      for (int i = 0; i < 3; i++)
         if (er[i]) sb.push_back('{a[i], d[i], 2'(i), 1'b0});
      @(posedge clk);
      #1;
      req_valid   = '0;
      clear_start = 1'b0;
   endtask

   task automatic push_clear();
      for (int i = 0; i < 32; i++)
         sb.push_back('{5'(i), 32'h0, 2'd3, i == 31});
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         tests++;
         if (RegWrite) begin
            if (sb.size() == 0) begin
               failed++;
               $display("FAIL unexpected_write: addr %0d data %0h gid %0d",
                        write_address, write_data, grant_id);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (write_address !== e.addr || write_data !== e.data ||
                   grant_id !== e.gid || clear_done !== e.done) begin
                  failed++;
                  $display({"FAIL write: got a=%0d d=%0h g=%0d done=%0b",
                            " want a=%0d d=%0h g=%0d done=%0b"},
                           write_address, write_data, grant_id, clear_done,
                           e.addr, e.data, e.gid, e.done);
               end
            end
         end else if (clear_done !== 1'b0) begin
            failed++;
            $display("FAIL clear_done_idle: got %b want 0", clear_done);
         end
      end
   end

   initial begin
      a = '{5'd1, 5'd2, 5'd3};
      d = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000};
      repeat (2) @(posedge clk);
      #1;
      chk("rst_regwrite", {31'd0, RegWrite}, 0);
      chk("rst_addr", {27'd0, write_address}, 0);
      chk("rst_data", write_data, 0);
      chk("rst_gid", {30'd0, grant_id}, 0);
      chk("rst_busy", {31'd0, clear_busy}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // all three requesting: grants 0,1,2
      step(3'b111, 1'b0, 3'b001);
      step(3'b111, 1'b0, 3'b010);
      step(3'b111, 1'b0, 3'b100);
      step(3'b000, 1'b0, 3'b000);

      // single requester 1
      a[1] = 5'd7;
      d[1] = 32'hDEAD_BEEF;
      step(3'b010, 1'b0, 3'b010);

      // idle, then search from 2 wraps to 0
      step(3'b000, 1'b0, 3'b000);
      step(3'b011, 1'b0, 3'b001);

      // clear beats a pending request; req 0 granted alongside clear_done
      step(3'b001, 1'b1, 3'b000);
      push_clear();
      chk("busy_in_clear", {31'd0, clear_busy}, 1);
      for (int i = 0; i < 32; i++) step(3'b001, 1'b0, 3'b000);
      step(3'b001, 1'b0, 3'b001);
      chk("busy_after_clear", {31'd0, clear_busy}, 0);

      // clear_start re-pulsed during clear is ignored
      step(3'b000, 1'b1, 3'b000);
      push_clear();
      for (int i = 0; i < 32; i++) step(3'b000, i == 5, 3'b000);
      step(3'b000, 1'b0, 3'b000);
      step(3'b000, 1'b0, 3'b000);
      chk("sb_empty_clear2", sb.size(), 0);

      // reset aborts a clear after the address-10 write
      step(3'b000, 1'b1, 3'b000);
      push_clear();
      begin
         int n = 0;
         while (!(RegWrite && write_address == 5'd10) && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk("reached_addr10", n < 100, 1);
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_regwrite", {31'd0, RegWrite}, 0);
      chk("arst_addr", {27'd0, write_address}, 0);
      chk("arst_data", write_data, 0);
      chk("arst_gid", {30'd0, grant_id}, 0);
      chk("arst_done", {31'd0, clear_done}, 0);
      chk("arst_busy", {31'd0, clear_busy}, 0);
      sb.delete();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) step(3'b000, 1'b0, 3'b000);

      // last_grant back to 2; same address serialized in grant order
      a = '{5'd5, 5'd5, 5'd9};
      d = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
      step(3'b111, 1'b0, 3'b001);
      step(3'b011, 1'b0, 3'b010);
      step(3'b011, 1'b0, 3'b001);
      step(3'b000, 1'b0, 3'b000);
      step(3'b000, 1'b0, 3'b000);
      chk("sb_empty_end", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
